// File: rtl/fifo_pkg.sv
// Shared sizing helpers, error-flag bundle and read-mode constants for the
// synchronous FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [ptr_w(DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [ptr_w(DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through reads.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   clr_err,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $fatal(1, "fifo_sync_flags: DATA_WIDTH must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "fifo_sync_flags: DEPTH must be a power of two >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "fifo_sync_flags: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "fifo_sync_flags: AE_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $fatal(1, "fifo_sync_flags: FWFT must be 0 or 1");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    fifo_err_t             err_q, err_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rdata;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_acc && !rd_acc) count_d = count_q + CNT_W'(1);
        if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
        // Clear first so a same-cycle set event takes priority.
        if (clr_err) err_d = '0;
        if (wr_en && full)  err_d.overflow  = 1'b1;
        if (rd_en && empty) err_d.underflow = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign dout = rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rdata;
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Randomized and directed checks of fifo_sync_flags in both read modes against
// a queue-based occupancy/data model.
module tb_fifo_sync_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, clr_err;
    logic [DW-1:0] din;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0]    s_count, f_count;

    int checks = 0;
    int passes = 0;

    // reference model
    logic [DW-1:0] q[$];
    logic          m_ovf, m_unf;
    logic [DW-1:0] m_dout;

    always #5 clk = ~clk;

    fifo_sync_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF),
                      .AE_THRESH(AE), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .clr_err(clr_err),
        .overflow(s_ovf), .underflow(s_unf));

    fifo_sync_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF),
                      .AE_THRESH(AE), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .clr_err(clr_err),
        .overflow(f_ovf), .underflow(f_unf));

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        @(posedge clk);
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
        #1 rst = 1'b0;
    endtask

    // One clock with the given inputs; model advances from its pre-edge state.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        logic [DW-1:0] popped;
        int sz;
        wr_en = w; din = d; rd_en = r; clr_err = c;
        @(posedge clk);
        sz = q.size();
        if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (w && sz == DEPTH) m_ovf = 1'b1;
        if (r && sz == 0)     m_unf = 1'b1;
        if (r && sz > 0) begin popped = q.pop_front(); m_dout = popped; end
        if (w && sz < DEPTH) q.push_back(d);
        #1 wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({s_count, s_empty, s_ae, s_full, s_af, s_ovf, s_unf, s_dout} !==
            {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset_state got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b dout=%0h",
                     s_count, s_empty, s_ae, s_full, s_af, s_ovf, s_unf, s_dout);
        else passes++;
        checks++;
        if ({f_count, f_empty, f_ovf, f_unf} !== {5'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_fwft got cnt=%0d e=%b ov=%b un=%b", f_count, f_empty, f_ovf, f_unf);
        else passes++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            checks++;
            if ({s_count, s_af, s_full} !== {5'(i + 1), (i + 1) >= AF, (i + 1) == DEPTH})
                $display("FAIL fill_flags got cnt=%0d af=%b f=%b exp cnt=%0d", s_count, s_af, s_full, i + 1);
            else passes++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (f_dout !== DW'(i))
                $display("FAIL drain_fwft_head got %0h exp %0h", f_dout, DW'(i));
            else passes++;
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (s_dout !== DW'(i))
                $display("FAIL drain_std_dout got %0h exp %0h", s_dout, DW'(i));
            else passes++;
        end
        checks++;
        if ({s_empty, s_ae, s_count} !== {1'b1, 1'b1, 5'd0})
            $display("FAIL drain_empty got e=%b ae=%b cnt=%0d", s_empty, s_ae, s_count);
        else passes++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        checks++;
        if ({s_count, s_ovf, s_full, s_dout} !== {5'd15, 1'b1, 1'b0, 8'h40})
            $display("FAIL overflow_set got cnt=%0d ov=%b f=%b dout=%0h exp 15 1 0 40",
                     s_count, s_ovf, s_full, s_dout);
        else passes++;
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        checks++;
        if ({s_count, s_full, s_ovf} !== {5'd16, 1'b1, 1'b1})
            $display("FAIL overflow_hold got cnt=%0d f=%b ov=%b exp 16 1 1", s_count, s_full, s_ovf);
        else passes++;
        // set beats clear in the same cycle
        step(1'b1, 8'hAC, 1'b0, 1'b1);
        checks++;
        if (s_ovf !== 1'b1)
            $display("FAIL overflow_set_wins got %b exp 1", s_ovf);
        else passes++;
        step(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if ({s_ovf, f_ovf} !== 2'b00)
            $display("FAIL overflow_clear got %b%b exp 00", s_ovf, f_ovf);
        else passes++;
        for (int i = 1; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if ({s_dout, s_empty} !== {8'hAB, 1'b1})
            $display("FAIL overflow_last_word got %0h e=%b exp ab 1", s_dout, s_empty);
        else passes++;
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if ({s_unf, s_count, s_dout} !== {1'b1, 5'd1, 8'h00})
            $display("FAIL underflow_set got un=%b cnt=%0d dout=%0h exp 1 1 0", s_unf, s_count, s_dout);
        else passes++;
        checks++;
        if ({f_unf, f_dout} !== {1'b1, 8'h55})
            $display("FAIL underflow_fwft got un=%b dout=%0h exp 1 55", f_unf, f_dout);
        else passes++;
        step(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if ({s_unf, s_count} !== {1'b0, 5'd1})
            $display("FAIL underflow_clear got un=%b cnt=%0d exp 0 1", s_unf, s_count);
        else passes++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(8'h80 + i), 1'b1, 1'b0);
            checks++;
            if ({s_count, s_dout, f_dout} !== {5'd8, m_dout, q[0]})
                $display("FAIL wrap_cycle%0d got cnt=%0d dout=%0h fw=%0h exp 8 %0h %0h",
                         i, s_count, s_dout, f_dout, m_dout, q[0]);
            else passes++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        checks++;
        if ({s_count, s_unf} !== {5'd10, 1'b1})
            $display("FAIL midrst_pre got cnt=%0d un=%b exp 10 1", s_count, s_unf);
        else passes++;
        do_reset();
        checks++;
        if ({s_count, s_empty, s_unf, s_ovf, f_count, f_unf} !== {5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0})
            $display("FAIL midrst_clear got cnt=%0d e=%b un=%b ov=%b", s_count, s_empty, s_unf, s_ovf);
        else passes++;
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if ({s_dout, s_empty} !== {8'h33, 1'b1})
            $display("FAIL midrst_data got %0h e=%b exp 33 1", s_dout, s_empty);
        else passes++;
    endtask

    task automatic test_random();
        int sz;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            // bias toward filling in the first half, draining in the second
            logic w, r, c;
            w = ($urandom_range(0, 99) < (i < 200 ? 70 : 35));
            r = ($urandom_range(0, 99) < (i < 200 ? 35 : 70));
            c = ($urandom_range(0, 99) < 5);
            step(w, DW'($urandom), r, c);
            sz = q.size();
            checks++;
            if ({s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_dout} !==
                {5'(sz), sz == DEPTH, sz == 0, sz >= AF, sz <= AE, m_ovf, m_unf, m_dout})
                $display("FAIL random%0d got cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b dout=%0h exp cnt=%0d ov=%b un=%b dout=%0h",
                         i, s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_dout, sz, m_ovf, m_unf, m_dout);
            else passes++;
            if (sz > 0) begin
                checks++;
                if ({f_count, f_dout} !== {5'(sz), q[0]})
                    $display("FAIL random_fwft%0d got cnt=%0d dout=%0h exp %0d %0h", i, f_count, f_dout, sz, q[0]);
                else passes++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO, next generation of the team's basic FIFO block. Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. Sits between producer and consumer logic in the same clock domain and replaces the basic FIFO wherever flow-control margin or error visibility is needed.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, 14, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
rd_en  in  1  read request (pop)
dout  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
clr_err  in  1  clears sticky error flags
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1 at a rising edge): wrt_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0 in standard mode. Memory contents are not reset. Reset mid-operation discards all stored data in one cycle.
- Write accepted iff wr_en && !full. The word is stored at mem[wrt_ptr] and wrt_ptr increments.
- Read accepted iff rd_en && !empty. rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- count update: +1 on write-only, -1 on read-only, unchanged when both are accepted or neither is.
- Simultaneous wr_en and rd_en:
  - When full: the read is accepted, the write is rejected, overflow is set, and count becomes DEPTH-1.
  - When empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- A rejected write or read changes no pointers and no count; it only sets the sticky flag.
- Sticky flags hold until clr_err=1 or reset. If a set event and clr_err occur in the same cycle, the set wins.
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count, so they are valid in the same cycle as count.
- Standard mode (FWFT=0): on an accepted read, dout is loaded with mem[rd_ptr] at that edge (1-cycle latency). Otherwise dout holds its value.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] continuously, so the head word is visible whenever !empty. rd_en acknowledges and pops it. dout is don't-care while empty. The first written word appears on dout the cycle after the write edge.
- Parameter legality is checked at elaboration; illegal DEPTH or thresholds raise $fatal.

Decomposition:
- Package fifo_pkg holds:
  - function for pointer width (PTR_W) and count width (CNT_W);
  - a typedef for the error-flag struct {overflow, underflow};
  - a FIFO_MODE_STD / FIFO_MODE_FWFT constant pair.
- Sub-module fifo_mem: simple dual-port array, one synchronous write port and one asynchronous read port, parametrised by DATA_WIDTH and DEPTH.
- Top level holds the pointers, count, flags and dout register.

Test Plan:
1. Reset then idle, DEPTH=16 -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, dout=0.
2. Write 0x00..0x0F back-to-back, then read 16 in standard mode:
   - almost_full rises on the edge where count reaches 14; full at count 16;
   - dout sequence 0x00..0x0F, each one cycle after its rd_en;
   - empty at the end.
3. Fill to 16, then drive wr_en=1 with din=0xAA plus rd_en=1 for one cycle -> read accepted, write dropped, count=15, overflow=1. Next wr_en-only cycle writes; pulse clr_err -> overflow=0.
4. Empty FIFO, rd_en=1 with wr_en=1, din=0x55 -> underflow=1, count=1. With FWFT=1, dout=0x55 on the following cycle without rd_en.
5. Half-full (count=8), simultaneous wr/rd for 20 cycles with din incrementing -> count stays 8, pointers wrap past 15->0, and data order is preserved.
6. Mid-stream rst=1 at count=10 -> next edge count=0, empty=1, and flags cleared. The following write of 0x33 and a read return 0x33.
